// File: rtl/rx_match.sv
// rx_match -- folded receive matched filter (33 symmetric taps), decimating by OSR.
//
// One multiply-accumulate per clock over a 33-entry circular sample buffer.
// Every OSR-th accepted sample triggers a 33-cycle MAC pass. The result is
// arithmetically shifted right by SHIFT and reduced to 32 bits, then held
// until out_ready.
//
// Optional build macro: RX_MATCH_SAT_EN
//   defined   -> the shifted result saturates to [-2^31, 2^31-1]
//   undefined -> the low 32 bits of the shifted result are kept (wrap)
//
// Ports:
//   clk        clock
//   rst        asynchronous active-high reset
//   xin        signed input sample (32 bits)
//   in_valid   xin valid
//   in_ready   a sample can be accepted (IDLE only)
//   yout       signed filtered, decimated result (32 bits)
//   bit_out    hard decision, 1 when yout >= 0
//   out_valid  yout/bit_out valid
//   out_ready  downstream accepts the output
module rx_match #(
  parameter int OSR   = 1,
  parameter int SHIFT = 15,
  parameter int ACC_W = 72
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [31:0] xin,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] yout,
  output logic               bit_out,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  localparam int PW = (OSR > 1) ? $clog2(OSR) : 1;

  state_t                   r_state;
  logic signed [31:0]       r_buf [33];
  logic [5:0]               r_wptr;
  logic [5:0]               r_rptr;
  logic [5:0]               r_k;
  logic [PW-1:0]            r_phase;
  logic signed [ACC_W-1:0]  r_acc;
  logic                     r_in_ready;
  logic                     r_out_valid;
  logic                     r_bit;
  logic signed [31:0]       r_yout;

  logic                     w_accept;
  logic                     w_trigger;
  logic signed [31:0]       w_coef;
  logic signed [31:0]       w_samp;
  logic [63:0]              w_prod;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [31:0]       w_y;

  // Only the first half of the symmetric response is stored; k > 16 folds onto 32-k.
  function automatic logic signed [31:0] coef(input logic [5:0] k);
    logic [5:0] idx;
    idx = (k > 6'd16) ? (6'd32 - k) : k;
    case (idx)
      6'd0:    coef =  32'sd1235;
      6'd1:    coef =  32'sd115;
      6'd2:    coef = -32'sd1280;
      6'd3:    coef = -32'sd2732;
      6'd4:    coef = -32'sd3965;
      6'd5:    coef = -32'sd4686;
      6'd6:    coef = -32'sd4627;
      6'd7:    coef = -32'sd3592;
      6'd8:    coef = -32'sd1496;
      6'd9:    coef =  32'sd1612;
      6'd10:   coef =  32'sd5538;
      6'd11:   coef =  32'sd9964;
      6'd12:   coef =  32'sd14478;
      6'd13:   coef =  32'sd18623;
      6'd14:   coef =  32'sd21960;
      6'd15:   coef =  32'sd24125;
      default: coef =  32'sd24874;
    endcase
  endfunction

  assign w_accept  = in_valid && r_in_ready;
  assign w_trigger = w_accept && (r_phase == PW'(OSR - 1));
  assign w_coef    = coef(r_k);
  assign w_samp    = r_buf[r_rptr];
  // Sign-extended operands make the low 64 bits the full signed product.
  assign w_prod    = {{32{w_coef[31]}}, w_coef} * {{32{w_samp[31]}}, w_samp};
  assign w_acc_next = r_acc + $signed({{(ACC_W-64){w_prod[63]}}, w_prod});

`ifdef RX_MATCH_SAT_EN
  localparam logic signed [ACC_W-1:0] MAXV = $signed({{(ACC_W-31){1'b0}}, {31{1'b1}}});
  localparam logic signed [ACC_W-1:0] MINV = $signed({{(ACC_W-31){1'b1}}, {31{1'b0}}});
  logic signed [ACC_W-1:0] w_shift;
  always_comb begin
    w_shift = w_acc_next >>> SHIFT;
    if (w_shift > MAXV)      w_y = 32'sh7FFF_FFFF;
    else if (w_shift < MINV) w_y = 32'sh8000_0000;
    else                     w_y = w_shift[31:0];
  end
`else
  always_comb begin
    w_y = 32'(w_acc_next >>> SHIFT);
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      for (int unsigned i = 0; i < 33; i++) r_buf[i] <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_k         <= '0;
      r_phase     <= '0;
      r_acc       <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_bit       <= 1'b0;
      r_yout      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_in_ready <= 1'b1;
          if (w_accept) begin
            r_buf[r_wptr] <= xin;
            r_wptr  <= (r_wptr == 6'd32) ? 6'd0 : r_wptr + 6'd1;
            r_phase <= (r_phase == PW'(OSR - 1)) ? '0 : r_phase + 1'b1;
            if (w_trigger) begin
              // MAC starts at the slot just written (x[n]) and walks backward.
              r_acc      <= '0;
              r_k        <= '0;
              r_rptr     <= r_wptr;
              r_in_ready <= 1'b0;
              r_state    <= S_MAC;
            end
          end
        end
        S_MAC: begin
          r_acc  <= w_acc_next;
          r_rptr <= (r_rptr == 6'd0) ? 6'd32 : r_rptr - 6'd1;
          r_k    <= r_k + 6'd1;
          if (r_k == 6'd32) begin
            r_yout      <= w_y;
            r_bit       <= ~w_y[31];
            r_out_valid <= 1'b1;
            r_state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign yout      = r_yout;
  assign bit_out   = r_bit;

endmodule
